// File: rtl/seg_decode38_if.sv
// rtl/seg_decode38_if.sv - segment-bus decoder interface: enable/pattern in, decode results out
interface seg_decode38_if;
  logic       i_en;
  logic [7:0] i_seg;
  logic [2:0] o_code;
  logic [7:0] o_onehot;
  logic       o_valid;
  logic       o_err;

  modport master (output i_en, i_seg, input o_code, o_onehot, o_valid, o_err);
  modport slave  (input i_en, i_seg, output o_code, o_onehot, o_valid, o_err);
endinterface

// File: rtl/seg_decode38.sv
// rtl/seg_decode38.sv - debounced 7-seg pattern to 3-bit code / one-hot decoder
module seg_decode38 #(
  parameter int STABLE_CYC = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_decode38_if.slave    bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, VALID, ERROR} state_t;

  state_t        r_state;
  logic [7:0]    r_s_seg;
  logic [CW-1:0] r_cnt;
  logic          r_chg;
  logic [2:0]    r_code;
  logic [7:0]    r_onehot;
  logic          r_valid;
  logic          r_err;

  logic [7:0]    w_n;
  logic          w_diff;
  logic          w_known;
  logic [2:0]    w_digit;

  assign w_n    = ACTIVE_LOW ? ~bus.i_seg : bus.i_seg;
  assign w_diff = (w_n != r_s_seg);

  always_comb begin
    w_known = 1'b1;
    w_digit = 3'd0;
    case (r_s_seg)
      8'b1111_1101: w_digit = 3'd0;
      8'b0110_0000: w_digit = 3'd1;
      8'b1101_1010: w_digit = 3'd2;
      8'b1111_0010: w_digit = 3'd3;
      8'b0110_0110: w_digit = 3'd4;
      8'b1011_0110: w_digit = 3'd5;
      8'b1011_1110: w_digit = 3'd6;
      8'b1110_0000: w_digit = 3'd7;
      default:      w_known = 1'b0;
    endcase
  end

  // r_chg remembers a change seen on the decision edge, so a decision made
  // just as the input moved is held for one cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s_seg  <= 8'h00;
      r_cnt    <= '0;
      r_chg    <= 1'b0;
      r_code   <= 3'd0;
      r_onehot <= 8'h00;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (!bus.i_en) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_chg    <= 1'b0;
      r_code   <= 3'd0;
      r_onehot <= 8'h00;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_s_seg <= w_n;
      r_chg   <= w_diff;
      if (r_state == IDLE || w_diff)
        r_cnt <= CNT_ONE;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_ONE;

      case (r_state)
        IDLE: r_state <= SETTLE;
        SETTLE: begin
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          if (r_cnt == CNT_MAX) begin
            if (w_known) begin
              r_state  <= VALID;
              r_code   <= w_digit;
              r_onehot <= 8'd1 << w_digit;
              r_valid  <= 1'b1;
            end else begin
              r_state  <= ERROR;
              r_onehot <= 8'h00;
              r_err    <= 1'b1;
            end
          end
        end
        VALID, ERROR: begin
          if (w_diff || r_chg) begin
            r_state  <= SETTLE;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_onehot <= 8'h00;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_code   = r_code;
  assign bus.o_onehot = r_onehot;
  assign bus.o_valid  = r_valid;
  assign bus.o_err    = r_err;

endmodule

// File: tb/tb_seg_decode38.sv
// tb/tb_seg_decode38.sv - self-checking bench for seg_decode38 with history-window reference model
module tb_seg_decode38;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_decode38_if bus();

  seg_decode38 #(.STABLE_CYC(S), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] dig [8] = '{8'hFD, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] hist [$];
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic [2:0] m_code = 3'd0;

  function automatic int lookup(input logic [7:0] p);
    for (int i = 0; i < 8; i++)
      if (dig[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [12:0] expv();
    logic [7:0] oh;
    oh = m_valid ? (8'd1 << m_code) : 8'h00;
    return {m_valid, m_err, m_code, oh};
  endfunction

  function automatic logic [12:0] gotv();
    return {bus.o_valid, bus.o_err, bus.o_code, bus.o_onehot};
  endfunction

  task automatic model_clear();
    hist.delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_code  = 3'd0;
  endtask

  // Decision after edge k: the S samples before the newest one agree, and either
  // this is the first edge that is true or the newest sample still agrees.
  task automatic drive_edge(input logic en, input logic [7:0] pat);
    int k;
    int d;
    logic uni;
    logic first;
    logic decided;
    bus.i_en  = en;
    bus.i_seg = ~pat;
    @(posedge clk);
    if (!en) begin
      model_clear();
    end else begin
      hist.push_back(pat);
      k = hist.size();
      decided = 1'b0;
      if (k >= S + 1) begin
        uni = 1'b1;
        for (int i = k - S; i <= k - 1; i++)
          if (hist[i-1] != hist[k-2]) uni = 1'b0;
        if (uni) begin
          first = (k - S - 1 < 1) || (hist[k-S-2] != hist[k-2]);
          if (first || hist[k-1] == hist[k-2]) decided = 1'b1;
        end
      end
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (decided) begin
        d = lookup(hist[k-2]);
        if (d >= 0) begin
          m_valid = 1'b1;
          m_code  = 3'(d);
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #2;
  endtask

  task automatic test_reset();
    bus.i_en  = 1'b1;
    bus.i_seg = ~dig[2];
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (gotv() !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", gotv(), 13'h0);
    end
    rst_n = 1'b1;
    model_clear();
    drive_edge(1'b0, 8'h00);
    n_chk++;
    if (gotv() !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_disabled: got %h expected %h", gotv(), 13'h0);
    end
  endtask

  task automatic test_valid_digit();
    drive_edge(1'b0, 8'h00);
    for (int e = 1; e <= 7; e++) begin
      drive_edge(1'b1, dig[2]);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL valid2_model e%0d: got %h expected %h", e, gotv(), expv());
      end
      if (e == 4) begin
        n_chk++;
        if (bus.o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL valid2_early: o_valid got %b expected 0", bus.o_valid);
        end
      end
      if (e == 5) begin
        n_chk++;
        if ({bus.o_valid, bus.o_err, bus.o_code, bus.o_onehot} !== {1'b1, 1'b0, 3'd2, 8'h04}) begin
          n_fail++;
          $display("FAIL valid2_edge5: got v=%b e=%b c=%0d oh=%h expected v=1 e=0 c=2 oh=04",
                   bus.o_valid, bus.o_err, bus.o_code, bus.o_onehot);
        end
      end
    end
  endtask

  task automatic test_glitch();
    drive_edge(1'b0, 8'h00);
    drive_edge(1'b1, dig[5]);
    drive_edge(1'b1, dig[5]);
    for (int e = 1; e <= 6; e++) begin
      drive_edge(1'b1, dig[3]);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL glitch_model e%0d: got %h expected %h", e, gotv(), expv());
      end
      if (e == 3) begin
        n_chk++;
        if (bus.o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_no_valid: o_valid got %b expected 0", bus.o_valid);
        end
      end
      if (e == 5) begin
        n_chk++;
        if ({bus.o_valid, bus.o_code, bus.o_onehot} !== {1'b1, 3'd3, 8'h08}) begin
          n_fail++;
          $display("FAIL glitch_code3: got v=%b c=%0d oh=%h expected v=1 c=3 oh=08",
                   bus.o_valid, bus.o_code, bus.o_onehot);
        end
      end
    end
  endtask

  task automatic test_invalid();
    drive_edge(1'b0, 8'h00);
    for (int e = 1; e <= 6; e++) begin
      drive_edge(1'b1, 8'hFF);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL invalid_model e%0d: got %h expected %h", e, gotv(), expv());
      end
      if (e == 5) begin
        n_chk++;
        if ({bus.o_err, bus.o_valid, bus.o_onehot} !== {1'b1, 1'b0, 8'h00}) begin
          n_fail++;
          $display("FAIL invalid_err: got err=%b v=%b oh=%h expected err=1 v=0 oh=00",
                   bus.o_err, bus.o_valid, bus.o_onehot);
        end
      end
    end
  endtask

  task automatic test_change_while_valid();
    drive_edge(1'b0, 8'h00);
    repeat (6) drive_edge(1'b1, dig[7]);
    n_chk++;
    if ({bus.o_valid, bus.o_code} !== {1'b1, 3'd7}) begin
      n_fail++;
      $display("FAIL chg_pre: got v=%b c=%0d expected v=1 c=7", bus.o_valid, bus.o_code);
    end
    for (int e = 1; e <= 6; e++) begin
      drive_edge(1'b1, dig[1]);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL chg_model e%0d: got %h expected %h", e, gotv(), expv());
      end
      if (e == 1) begin
        n_chk++;
        if ({bus.o_valid, bus.o_code, bus.o_onehot} !== {1'b0, 3'd7, 8'h00}) begin
          n_fail++;
          $display("FAIL chg_drop: got v=%b c=%0d oh=%h expected v=0 c=7 oh=00",
                   bus.o_valid, bus.o_code, bus.o_onehot);
        end
      end
      if (e == 5) begin
        n_chk++;
        if ({bus.o_valid, bus.o_code, bus.o_onehot} !== {1'b1, 3'd1, 8'h02}) begin
          n_fail++;
          $display("FAIL chg_code1: got v=%b c=%0d oh=%h expected v=1 c=1 oh=02",
                   bus.o_valid, bus.o_code, bus.o_onehot);
        end
      end
    end
  endtask

  task automatic test_disable();
    drive_edge(1'b0, 8'h00);
    repeat (5) drive_edge(1'b1, dig[6]);
    drive_edge(1'b0, dig[6]);
    n_chk++;
    if (gotv() !== 13'h0) begin
      n_fail++;
      $display("FAIL disable_clear: got %h expected %h", gotv(), 13'h0);
    end
    for (int e = 1; e <= 5; e++) begin
      drive_edge(1'b1, dig[6]);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL reenable_model e%0d: got %h expected %h", e, gotv(), expv());
      end
    end
    n_chk++;
    if ({bus.o_valid, bus.o_code, bus.o_onehot} !== {1'b1, 3'd6, 8'h40}) begin
      n_fail++;
      $display("FAIL reenable_code6: got v=%b c=%0d oh=%h expected v=1 c=6 oh=40",
               bus.o_valid, bus.o_code, bus.o_onehot);
    end
  endtask

  task automatic test_async_reset();
    drive_edge(1'b0, 8'h00);
    repeat (5) drive_edge(1'b1, dig[4]);
    n_chk++;
    if (bus.o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: o_valid got %b expected 1", bus.o_valid);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (gotv() !== 13'h0) begin
      n_fail++;
      $display("FAIL arst_immediate: got %h expected %h", gotv(), 13'h0);
    end
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int e = 1; e <= 5; e++) begin
      drive_edge(1'b1, dig[4]);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL arst_resettle e%0d: got %h expected %h", e, gotv(), expv());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pat;
    logic       en;
    int         r;
    pat = dig[0];
    en  = 1'b1;
    for (int e = 0; e < 600; e++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) en = ~en;
      else if (r < 10) pat = dig[$urandom_range(0, 7)];
      else if (r < 12) pat = 8'hFE;
      else if (r < 14) pat = 8'hF6;
      else if (r < 17) pat = 8'($urandom);
      drive_edge(en, pat);
      n_chk++;
      if (gotv() !== expv()) begin
        n_fail++;
        $display("FAIL random_model e%0d: got %h expected %h", e, gotv(), expv());
      end
      n_chk++;
      if ((bus.o_valid && bus.o_err) || (!bus.o_valid && bus.o_onehot != 8'h00)) begin
        n_fail++;
        $display("FAIL random_exclusive e%0d: got v=%b e=%b oh=%h expected v&e=0 and oh=00 unless valid",
                 e, bus.o_valid, bus.o_err, bus.o_onehot);
      end
    end
  endtask

  initial begin
    bus.i_en  = 1'b0;
    bus.i_seg = 8'hFF;
    test_reset();
    test_valid_digit();
    test_glitch();
    test_invalid();
    test_change_while_valid();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
